// File: rtl/ps2_keyboard_tx_if.sv
// ----------------------------------------------------------------------------
// ps2_keyboard_tx_if
// Bundles the host-side queue interface and the PS/2 line outputs of the
// device-side keyboard transmitter.
//   wr_en / wr_data : push one scan-code byte into the transmit FIFO
//   inhibit         : host holds the clock low (abort / block frames)
//   full            : FIFO holds 8 entries
//   busy            : FIFO non-empty or a frame/gap in progress
//   overflow        : sticky, a push was attempted while full
//   ps2_clk/ps2_data: generated PS/2 lines
// master = byte source / host side, slave = transmitter.
// ----------------------------------------------------------------------------
interface ps2_keyboard_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       inhibit;
    logic       full;
    logic       busy;
    logic       overflow;
    logic       ps2_clk;
    logic       ps2_data;

    modport master (
        output wr_en, wr_data, inhibit,
        input  full, busy, overflow, ps2_clk, ps2_data
    );

    modport slave (
        input  wr_en, wr_data, inhibit,
        output full, busy, overflow, ps2_clk, ps2_data
    );
endinterface

// File: rtl/ps2_keyboard_tx.sv
// ----------------------------------------------------------------------------
// ps2_keyboard_tx
// Device-side PS/2 keyboard transmitter. Queued bytes (8-entry FIFO) are sent
// as 11-bit frames: start 0, data LSB first, odd parity, stop 1. Both PS/2
// lines are generated here; a host inhibit aborts the current frame, which is
// retransmitted later because the FIFO head is only popped on completion.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-low
//   bus  : ps2_keyboard_tx_if.slave (wr_en, wr_data, inhibit in;
//          full, busy, overflow, ps2_clk, ps2_data out, all registered)
// Parameters:
//   CLK_HALF : clk cycles per ps2_clk half-period (>= 2)
//   GAP      : idle clk cycles between frames (>= 1)
// ----------------------------------------------------------------------------
module ps2_keyboard_tx #(
    parameter int unsigned CLK_HALF = 50,
    parameter int unsigned GAP      = 200
) (
    input  logic             clk,
    input  logic             rst,
    ps2_keyboard_tx_if.slave bus
);
    localparam int unsigned HW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_HALF - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
    localparam logic [3:0]    STOP_BIT  = 4'd10;

    typedef enum logic [2:0] {S_IDLE, S_HIGH, S_LOW, S_GAP, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] half_q, half_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    frame_q, frame_d;       // {parity, data, start}; stop is implied

    logic [7:0]    mem_q [8];
    logic [2:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0]    count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          full_q, full_d, busy_q, busy_d;
    logic          ps2_clk_q, ps2_clk_d, ps2_data_q, ps2_data_d;

    logic          push, pop, load, start_ok;
    logic [7:0]    head;
    logic [10:0]   bits_d;

    assign head     = mem_q[rptr_q];
    assign push     = bus.wr_en && (count_q != 4'd8);
    assign start_ok = (count_q != 4'd0) && !bus.inhibit;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            half_q     <= '0;
            gap_q      <= '0;
            bit_q      <= '0;
            frame_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            gap_q      <= gap_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            full_q     <= full_d;
            busy_q     <= busy_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= bus.wr_data;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        pop     = 1'b0;
        load    = 1'b0;

        case (state_q)
            S_IDLE: load = start_ok;
            S_HIGH: begin
                if (bus.inhibit) begin
                    state_d = S_HOLD;
                end else if (half_q == HALF_LAST) begin
                    half_d  = '0;
                    state_d = S_LOW;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            S_LOW: begin
                if (bus.inhibit) begin
                    state_d = S_HOLD;
                end else if (half_q == HALF_LAST) begin
                    half_d = '0;
                    if (bit_q == STOP_BIT) begin
                        pop     = 1'b1;
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = S_HIGH;
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            S_GAP: begin
                // The IDLE start decision is folded into the last gap cycle so
                // back-to-back frames are separated by exactly GAP idle cycles.
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    load    = start_ok;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (!bus.inhibit) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            state_d = S_HIGH;
            frame_d = {~^head, head, 1'b0};
            bit_d   = '0;
            half_d  = '0;
        end

        wptr_d = push ? wptr_q + 3'd1 : wptr_q;
        rptr_d = pop  ? rptr_q + 3'd1 : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 4'd1;
        end else if (!push && pop) begin
            count_d = count_q - 4'd1;
        end
        // A push while full is dropped even if a pop happens in the same cycle.
        overflow_d = overflow_q | (bus.wr_en && (count_q == 4'd8));
    end

    // Output logic: next values of the registered outputs from the next state.
    always_comb begin
        bits_d     = {1'b1, frame_d};
        ps2_clk_d  = (state_d != S_LOW);
        ps2_data_d = 1'b1;
        if ((state_d == S_HIGH) || (state_d == S_LOW)) begin
            ps2_data_d = bits_d[bit_d];
        end
        busy_d = (count_d != 4'd0) || (state_d != S_IDLE);
        full_d = (count_d == 4'd8);
    end

    assign bus.full     = full_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;
    assign bus.ps2_clk  = ps2_clk_q;
    assign bus.ps2_data = ps2_data_q;

endmodule
